// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_8n1_if.sv
// Serial line, divider configuration and received-byte outputs of the UART receiver.
interface uart_rx_8n1_if
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) ();

  logic                 ser_rx;
  logic [DIV_WIDTH-1:0] cfg_divider;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 starting;

  // Line driver / consumer side.
  modport master (
    output ser_rx,
    output cfg_divider,
    input  data,
    input  valid,
    input  starting
  );

  // Receiver side.
  modport slave (
    input  ser_rx,
    input  cfg_divider,
    output data,
    output valid,
    output starting
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single asynchronous bit; resets to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops in series; both come out of reset high so an idle line never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 asynchronous serial receiver with a run-time bit-period divider.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_8n1_if.slave  bus
);

  logic                 rx_s;
  logic [DIV_WIDTH-1:0] div_cfg_c;
  logic [DIV_WIDTH-1:0] half_c;
  logic [DIV_WIDTH-1:0] last_c;

  rx_state_e            state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 starting_q;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.ser_rx),
    .q     (rx_s)
  );

  // Clamp the configured divider so a half period is always at least one clock.
  always_comb begin
    div_cfg_c = bus.cfg_divider;
    if (bus.cfg_divider < DIV_WIDTH'(MIN_DIV)) begin
      div_cfg_c = DIV_WIDTH'(MIN_DIV);
    end
  end

  // Mid-start and full-period compare points derived from the divider latched for this frame.
  always_comb begin
    half_c = div_q >> 1;
    last_c = div_q - DIV_WIDTH'(1);
  end

  // Frame state machine: detect start, confirm at mid-start, sample each bit one period later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      div_q      <= DIV_WIDTH'(MIN_DIV);
      bit_idx    <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      starting_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= DIV_WIDTH'(1);
            div_q <= div_cfg_c;
            state <= START;
          end
        end
        START: begin
          if (cnt == half_c) begin
            if (!rx_s) begin
              starting_q <= 1'b1;
              cnt        <= '0;
              bit_idx    <= '0;
              state      <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (cnt == last_c) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'(1);
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (cnt == last_c) begin
            // A low stop bit is a framing error: drop the byte silently.
            if (rx_s) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end
            starting_q <= 1'b0;
            cnt        <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + DIV_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.starting = starting_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: table of single frames plus hand-written corner sequences.
module tb_uart_rx_8n1;

  logic clk;
  logic reset;

  uart_rx_8n1_if #(.DIV_WIDTH(32)) bus ();

  uart_rx_8n1 #(.DIV_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cfg;
    int          clks;
    logic [7:0]  tx;
    logic        stop_bit;
    int          exp_pulses;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t       vecs[8];
  int         n_tests;
  int         n_fail;
  int         pulses;
  int         overlap;
  bit         start_seen;
  logic [7:0] rx_q[$];

  // Observe outputs on the falling edge: count pulses, log bytes, flag starting/valid overlap.
  always @(negedge clk) begin
    if (bus.valid) begin
      pulses = pulses + 1;
      rx_q.push_back(bus.data);
    end
    if (bus.valid && bus.starting) overlap = overlap + 1;
    if (bus.starting) start_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called and returns 1 time unit after a rising edge; drives one complete frame.
  task automatic send_byte(input logic [7:0] b, input int clks, input logic stop_bit);
    bus.ser_rx = 1'b0;
    repeat (clks) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.ser_rx = b[i];
      repeat (clks) @(posedge clk);
      #1;
    end
    bus.ser_rx = stop_bit;
    repeat (clks) @(posedge clk);
    #1;
    bus.ser_rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int n;
    logic [7:0] b;

    n_tests    = 0;
    n_fail     = 0;
    pulses     = 0;
    overlap    = 0;
    start_seen = 1'b0;

    //              cfg  clks  tx     stop pulses data
    vecs[0] = '{32'd16,  16, 8'h00, 1'b1, 1, 8'h00};
    vecs[1] = '{32'd16,  16, 8'hFF, 1'b1, 1, 8'hFF};
    vecs[2] = '{32'd16,  16, 8'h55, 1'b0, 0, 8'hFF};  // framing error keeps previous byte
    vecs[3] = '{32'd16,  16, 8'h31, 1'b1, 1, 8'h31};
    vecs[4] = '{32'd0,    2, 8'h5A, 1'b1, 1, 8'h5A};  // divider 0 clamps to 2
    vecs[5] = '{32'd1,    2, 8'hC3, 1'b1, 1, 8'hC3};  // divider 1 clamps to 2
    vecs[6] = '{32'd5,    5, 8'h96, 1'b1, 1, 8'h96};  // odd divider
    vecs[7] = '{32'd217, 217, 8'h61, 1'b1, 1, 8'h61}; // 25 MHz / 115200

    reset           = 1'b1;
    bus.ser_rx      = 1'b1;
    bus.cfg_divider = 32'd16;
    idle(4);
    check("reset_data", 32'(bus.data), 32'h00);
    check("reset_valid", 32'(bus.valid), 32'h0);
    check("reset_starting", 32'(bus.starting), 32'h0);
    reset = 1'b0;
    idle(4);

    // 'A' at 16 clk/bit: 2 sync + 1 detect + 8 to mid-start = starting visible 11 edges after the fall.
    p0 = pulses;
    n  = 0;
    fork
      send_byte(8'h41, 16, 1'b1);
      begin
        while (!bus.starting && n < 40) begin
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    check("A_start_latency", 32'(n), 32'd11);
    idle(20);
    check("A_pulses", 32'(pulses - p0), 32'd1);
    check("A_data", 32'(bus.data), 32'h41);
    check("A_starting_low", 32'(bus.starting), 32'h0);

    // Table of single frames.
    for (int i = 0; i < 8; i++) begin
      bus.cfg_divider = vecs[i].cfg;
      idle(2);
      p0 = pulses;
      send_byte(vecs[i].tx, vecs[i].clks, vecs[i].stop_bit);
      idle(vecs[i].clks + 20);
      check($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'(vecs[i].exp_pulses));
      check($sformatf("vec%0d_data", i), 32'(bus.data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_starting", i), 32'(bus.starting), 32'h0);
    end

    // Back-to-back frames with no idle gap.
    bus.cfg_divider = 32'd16;
    idle(4);
    rx_q.delete();
    p0 = pulses;
    send_byte(8'h0D, 16, 1'b1);
    send_byte(8'h7F, 16, 1'b1);
    send_byte(8'h30, 16, 1'b1);
    idle(40);
    check("b2b_pulses", 32'(pulses - p0), 32'd3);
    b = (rx_q.size() > 0) ? rx_q[0] : 8'hXX;
    check("b2b_byte0", 32'(b), 32'h0D);
    b = (rx_q.size() > 1) ? rx_q[1] : 8'hXX;
    check("b2b_byte1", 32'(b), 32'h7F);
    b = (rx_q.size() > 2) ? rx_q[2] : 8'hXX;
    check("b2b_byte2", 32'(b), 32'h30);

    // Glitch: 4 clk low pulse at divider 16 must not confirm a start.
    p0         = pulses;
    start_seen = 1'b0;
    bus.ser_rx = 1'b0;
    idle(4);
    bus.ser_rx = 1'b1;
    idle(40);
    check("glitch_starting_seen", 32'(start_seen), 32'h0);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_data", 32'(bus.data), 32'h30);

    // Reset during data bit 4 of 0xA5.
    b          = 8'hA5;
    bus.ser_rx = 1'b0;
    idle(16);
    for (int i = 0; i < 4; i++) begin
      bus.ser_rx = b[i];
      idle(16);
    end
    bus.ser_rx = b[4];
    idle(8);
    check("rst_pre_starting", 32'(bus.starting), 32'h1);
    reset = 1'b1;
    idle(1);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_starting", 32'(bus.starting), 32'h0);
    check("rst_data", 32'(bus.data), 32'h00);
    reset      = 1'b0;
    bus.ser_rx = 1'b1;
    idle(48);
    check("rst_idle_data", 32'(bus.data), 32'h00);
    p0 = pulses;
    send_byte(8'hA5, 16, 1'b1);
    idle(30);
    check("rst_after_pulses", 32'(pulses - p0), 32'd1);
    check("rst_after_data", 32'(bus.data), 32'hA5);

    check("valid_starting_overlap", 32'(overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- Asynchronous serial receiver, 8N1 framing (1 start bit, 8 data bits LSB first, 1 stop bit, no parity).
- Bit period is set at run time by `cfg_divider`.
- Feeds the serial-keyboard decoder: one received byte gives one `valid` pulse.
- Exposes a `starting` flag so the consumer can clear its key state when a new frame begins.

Parameters:
- DIV_WIDTH, 32, width of `cfg_divider` and of the internal bit-period counter.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ser_rx  input  1  asynchronous serial line; idle high
- cfg_divider  input  DIV_WIDTH  clk cycles per bit (for example 25000000/115200 = 217)
- data  output  8  last correctly received byte
- valid  output  1  one-cycle pulse when `data` is updated
- starting  output  1  high from start-bit confirmation until the frame ends

Behaviour:
- Input path:
  - `ser_rx` passes through a 2-FF synchronizer; the reset value of both stages is 1.
  - All decisions below use the synchronized signal `rx_s`.
- Effective divider:
  - div = max(`cfg_divider`, 2); values 0 and 1 are clamped to 2.
  - half = div >> 1.
  - `cfg_divider` is sampled into a register when a start edge is detected; changes mid-frame have no effect until the next frame.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - On `rx_s` == 0: load counter = 1, go to START.
- START:
  - Counter increments each cycle.
  - When counter == half: if `rx_s` == 0, the start bit is confirmed. Set `starting` = 1, clear the counter, clear the bit index, go to DATA. Otherwise it was a glitch: go to IDLE with no `valid`.
- DATA:
  - Counter increments each cycle.
  - When counter == div-1 (one full period after mid-start): shift `rx_s` into the shift register MSB, shift right, clear the counter, increment the bit index.
  - After the 8th sample, go to STOP. The first received bit ends in `data[0]`.
- STOP:
  - When counter == div-1, sample the stop bit.
  - If `rx_s` == 1: `data` <= shift register, `valid` = 1 for exactly one cycle.
  - If `rx_s` == 0 (framing error): `data` is unchanged and no `valid` pulse.
  - In both cases `starting` <= 0 and the state returns to IDLE.
  - If the line is still low after a framing error, IDLE re-detects a start immediately. This is accepted behaviour.
- Latency: `valid` rises on the cycle after the clock edge that samples mid-stop. That is about 2 + half + 9·div clocks after the falling edge of `ser_rx`.
- `starting` and `valid` are never high in the same cycle.
- `data` holds its value between frames.
- Back-to-back frames: a new start bit is accepted on the cycle after returning to IDLE, so a stop-bit length of half a bit period is tolerated.
- Reset (any cycle, including mid-frame):
  - State = IDLE, counter = 0, bit index = 0, shift register = 0.
  - `data` = 8'h00, `valid` = 0, `starting` = 0, synchronizer = 1.
  - Any partial frame is discarded.
- Widths: counter is DIV_WIDTH bits; bit index is 3 bits plus terminal detect; all compares are unsigned.

Decomposition:
- Shared package `uart_pkg`: state enum {IDLE, START, DATA, STOP}, constant DATA_BITS = 8, constant MIN_DIV = 2.
- One natural sub-module: `sync_2ff` (2-stage synchronizer, reset value 1).
- Everything else stays in one always block plus output registers.

Test Plan:
- Normal frame: `cfg_divider` = 16, send 0x41 ('A') at 16 clk/bit.
  - `starting` rises about 10 clk after the falling edge.
  - `valid` pulses once, with `data` == 0x41.
  - `starting` is low in the `valid` cycle.
- Back-to-back frames: `cfg_divider` = 16, send 0x0D, 0x7F, 0x30 with no gap → three `valid` pulses, `data` = 0x0D, 0x7F, 0x30 in order, no missed bytes.
- Glitch rejection: pull `ser_rx` low for 4 clk (divider 16) → `starting` never asserts, no `valid`, state back to IDLE.
- Framing error: send 0x55 with stop bit forced low → no `valid`, `data` keeps its previous value, `starting` returns to 0. A following good 0x31 frame is received correctly.
- Reset mid-frame: assert `reset` during data bit 4 of 0xA5 → `valid`, `starting` and `data` = 0 next cycle. A subsequent clean 0xA5 frame yields `data` == 0xA5.
- Divider clamp and real baud:
  - `cfg_divider` = 0 with 2 clk/bit stimulus of 0x5A → `data` == 0x5A.
  - `cfg_divider` = 217 with 217 clk/bit of 0x61 → `data` == 0x61.
